// File: rtl/z3_dma_sequencer_if.sv
// z3_dma_sequencer_if: bundles the SCSI-side local cycle, the Zorro III
// handshake inputs and the sequencer's registered bus outputs.
// The master modport is the sequencer; the slave modport is whatever
// drives the local cycle and the Zorro responses (chip, bus, bench).
//
// Handshake: a local cycle is requested while BMASTER=1 and SCSI_AS_n=0;
// SIZ, A and READ must be stable at that edge. The cycle is acknowledged
// by a single-CLK SCSI_STERM_n low (good) or a single-CLK DMA_BERR high
// (aborted); SCSI_AS_n must then return high before another cycle starts.
interface z3_dma_sequencer_if;
  logic       BMASTER;
  logic       SCSI_AS_n;
  logic       READ;
  logic [1:0] SIZ;
  logic [1:0] A;
  logic       ZORRO_FCS_n;
  logic       ZORRO_DTACK_n;
  logic       BERR_n;

  logic       DMA_FCS_n;
  logic [3:0] DMA_DS_n;
  logic       DMA_DOE;
  logic       SCSI_STERM_n;
  logic       BFCS_out;
  logic       DMA_BERR;
  logic       DMA_BUSY;
  logic [2:0] dbg_state;

  modport master (
    input  BMASTER, SCSI_AS_n, READ, SIZ, A, ZORRO_FCS_n, ZORRO_DTACK_n, BERR_n,
    output DMA_FCS_n, DMA_DS_n, DMA_DOE, SCSI_STERM_n, BFCS_out, DMA_BERR,
           DMA_BUSY, dbg_state
  );

  modport slave (
    output BMASTER, SCSI_AS_n, READ, SIZ, A, ZORRO_FCS_n, ZORRO_DTACK_n, BERR_n,
    input  DMA_FCS_n, DMA_DS_n, DMA_DOE, SCSI_STERM_n, BFCS_out, DMA_BERR,
           DMA_BUSY, dbg_state
  );
endinterface

// File: rtl/z3_dma_sequencer.sv
// z3_dma_sequencer: turns one NCR SCSI local DMA cycle into one Zorro III
// bus-master cycle (FCS_n, DS_n lanes, DOE), waits for DTACK_n / BERR_n and
// returns SCSI_STERM_n. All outputs are registered.
// Optional feature macro: DMA_TIMEOUT_EN -- when defined, a cycle stuck in
// DATA/WAIT for TIMEOUT_CYCLES clocks is aborted exactly like a bus error.
// The FSM state is exported on bus.dbg_state for checkers.
module z3_dma_sequencer #(
  parameter int FCS_SETUP      = 1,   // 1..7 clocks of FCS_n before DS_n
  parameter int TIMEOUT_CYCLES = 64,  // used only with DMA_TIMEOUT_EN
  parameter int SYNC_STAGES    = 2    // synchroniser depth on DTACK_n/BERR_n
) (
  input logic                CLK,
  input logic                RESET,
  z3_dma_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_WAIT    = 3'd3,
    S_TERM    = 3'd4,
    S_RECOVER = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  localparam logic [2:0] SETUP_LAST = 3'(FCS_SETUP - 1);

  state_t     state_q;
  logic [2:0] setup_cnt_q;
  logic [1:0] siz_q;
  logic [1:0] a_q;
  logic       read_q;

  logic       fcs_q;
  logic [3:0] ds_q;
  logic       doe_q;
  logic       sterm_q;
  logic       berr_q;
  logic       busy_q;
  logic       bfcs_q;

  logic [SYNC_STAGES-1:0] dtack_sync_q;
  logic [SYNC_STAGES-1:0] berr_sync_q;
  logic                   dtack_s;
  logic                   berr_s;
  logic                   tmo_hit;
  logic                   in_transfer;

  // Active-low lane strobes for a 68030-style transfer of SIZ bytes at
  // offset A; lanes past byte 3 are dropped (the chip resizes the rest).
  function automatic logic [3:0] lane_mask(input logic [1:0] siz,
                                           input logic [1:0] a);
    logic [2:0] n;
    logic [3:0] m;
    n = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
    m = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if ((i >= int'(a)) && (i < int'(a) + int'(n))) m[3-i] = 1'b0;
    end
    return m;
  endfunction

  // Synchronise the asynchronous Zorro DTACK_n and BERR_n; idle high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dtack_sync_q <= '1;
      berr_sync_q  <= '1;
    end else begin
      dtack_sync_q[0] <= bus.ZORRO_DTACK_n;
      berr_sync_q[0]  <= bus.BERR_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dtack_sync_q[i] <= dtack_sync_q[i-1];
        berr_sync_q[i]  <= berr_sync_q[i-1];
      end
    end
  end

  assign dtack_s     = dtack_sync_q[SYNC_STAGES-1];
  assign berr_s      = berr_sync_q[SYNC_STAGES-1];
  assign in_transfer = (state_q == S_DATA) || (state_q == S_WAIT);

`ifdef DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt_q;

  // Count clocks spent in DATA/WAIT; zero whenever outside, so it is
  // already clear on entry to DATA.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmo_cnt_q <= '0;
    end else if (in_transfer) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit = in_transfer && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout a cycle waits for DTACK, BERR or BMASTER loss.
  assign tmo_hit = 1'b0;
`endif

  // Cycle sequencer: state plus every registered strobe and status output.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      setup_cnt_q <= 3'd0;
      siz_q       <= 2'b00;
      a_q         <= 2'b00;
      read_q      <= 1'b1;
      fcs_q       <= 1'b1;
      ds_q        <= 4'hF;
      doe_q       <= 1'b0;
      sterm_q     <= 1'b1;
      berr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // STERM_n and DMA_BERR are single-clock pulses unless re-asserted.
      sterm_q <= 1'b1;
      berr_q  <= 1'b0;
      if ((state_q != S_IDLE) && !bus.BMASTER) begin
        // Lost the bus: abandon silently, no STERM and no bus error.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        fcs_q   <= 1'b1;
        ds_q    <= 4'hF;
        doe_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.BMASTER && !bus.SCSI_AS_n) begin
              siz_q       <= bus.SIZ;
              a_q         <= bus.A;
              read_q      <= bus.READ;
              setup_cnt_q <= 3'd0;
              fcs_q       <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (setup_cnt_q == SETUP_LAST) begin
              ds_q    <= lane_mask(siz_q, a_q);
              doe_q   <= !read_q;
              state_q <= S_DATA;
            end else begin
              setup_cnt_q <= setup_cnt_q + 3'd1;
            end
          end
          S_DATA, S_WAIT: begin
            if (!berr_s || tmo_hit) begin
              // Bus error beats DTACK arriving on the same clock.
              fcs_q   <= 1'b1;
              ds_q    <= 4'hF;
              doe_q   <= 1'b0;
              berr_q  <= 1'b1;
              state_q <= S_ERR;
            end else if (!dtack_s) begin
              sterm_q <= 1'b0;
              state_q <= S_TERM;
            end else begin
              state_q <= S_WAIT;
            end
          end
          S_TERM: begin
            fcs_q   <= 1'b1;
            ds_q    <= 4'hF;
            doe_q   <= 1'b0;
            state_q <= S_RECOVER;
          end
          S_RECOVER: begin
            // Target must release DTACK and the chip must end its cycle.
            if (dtack_s && bus.SCSI_AS_n) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          S_ERR: begin
            if (bus.SCSI_AS_n) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: begin
            fcs_q   <= 1'b1;
            ds_q    <= 4'hF;
            doe_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Buffered FCS for slave decode: our own FCS while master, else the bus.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bfcs_q <= 1'b1;
    end else begin
      bfcs_q <= bus.BMASTER ? fcs_q : bus.ZORRO_FCS_n;
    end
  end

  assign bus.DMA_FCS_n    = fcs_q;
  assign bus.DMA_DS_n     = ds_q;
  assign bus.DMA_DOE      = doe_q;
  assign bus.SCSI_STERM_n = sterm_q;
  assign bus.BFCS_out     = bfcs_q;
  assign bus.DMA_BERR     = berr_q;
  assign bus.DMA_BUSY     = busy_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_z3_dma_sequencer.sv
// Testbench for z3_dma_sequencer: directed scenarios plus randomized
// transfers scored against a byte-lane model. Build with +define+DMA_TIMEOUT_EN
// to exercise the timeout path.
module tb_z3_dma_sequencer;
  localparam int FCS_SETUP   = 1;
  localparam int TB_TIMEOUT  = 8;
  localparam int SYNC_STAGES = 2;

  logic CLK = 1'b0;
  logic RESET;

  z3_dma_sequencer_if bus ();

  z3_dma_sequencer #(
    .FCS_SETUP      (FCS_SETUP),
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];   // {doe, ds_n} per scored transfer

  // results of the last run_txn
  logic [3:0] r_ds;
  logic       r_doe;
  int         r_setup;
  int         r_lat;
  bit         r_held;
  logic [6:0] r_rel;
  bit         r_ok;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.BMASTER       = 1'b1;
    bus.SCSI_AS_n     = 1'b1;
    bus.READ          = 1'b1;
    bus.SIZ           = 2'b00;
    bus.A             = 2'b00;
    bus.ZORRO_FCS_n   = 1'b1;
    bus.ZORRO_DTACK_n = 1'b1;
    bus.BERR_n        = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic start_cycle(input logic [1:0] siz, input logic [1:0] a, input logic rd);
    bus.SIZ       = siz;
    bus.A         = a;
    bus.READ      = rd;
    bus.SCSI_AS_n = 1'b0;
  endtask

  // Returns just after the edge on which DS_n lanes assert.
  task automatic wait_data(output int fcs_cycles, output bit ok);
    fcs_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.DMA_DS_n !== 4'hF) begin
        ok = 1'b1;
        break;
      end
      if (bus.DMA_FCS_n === 1'b0) fcs_cycles++;
    end
  endtask

  task automatic end_cycle(output bit ok);
    bus.ZORRO_DTACK_n = 1'b1;
    bus.BERR_n        = 1'b1;
    bus.SCSI_AS_n     = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.DMA_BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One complete good transfer with DTACK asserted dly clocks into DATA.
  task automatic run_txn(input logic [1:0] siz, input logic [1:0] a,
                         input logic rd, input int dly);
    bit ok1, ok2, ok3;
    start_cycle(siz, a, rd);
    wait_data(r_setup, ok1);
    r_ds   = bus.DMA_DS_n;
    r_doe  = bus.DMA_DOE;
    r_held = 1'b1;
    repeat (dly) begin
      tick();
      if (bus.DMA_DS_n !== r_ds || bus.DMA_DOE !== r_doe) r_held = 1'b0;
    end
    bus.ZORRO_DTACK_n = 1'b0;
    r_lat = 0;
    ok2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      r_lat++;
      if (bus.DMA_DS_n !== r_ds || bus.DMA_DOE !== r_doe) r_held = 1'b0;
      if (bus.SCSI_STERM_n === 1'b0) begin
        ok2 = 1'b1;
        break;
      end
    end
    tick();
    r_rel = {bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.SCSI_STERM_n};
    end_cycle(ok3);
    r_ok = ok1 && ok2 && ok3;
  endtask

  // ---------------- reference model ----------------
  // Bytes covered are A .. A+len-1 clipped at byte 3; byte k is DS_n[3-k].
  function automatic logic [3:0] model_lanes(input logic [1:0] siz, input logic [1:0] a);
    int len, last, width;
    logic [7:0] active;
    len   = (siz == 2'b00) ? 4 : int'(siz);
    last  = int'(a) + len - 1;
    if (last > 3) last = 3;
    width = last - int'(a) + 1;
    active = 8'((1 << width) - 1) << (3 - last);
    return ~active[3:0];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.SCSI_STERM_n, bus.BFCS_out,
         bus.DMA_BERR, bus.DMA_BUSY} !== 10'b1_1111_0_1_1_0_0) begin
      errors++;
      $display("FAIL reset_values got %b want %b",
               {bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.SCSI_STERM_n, bus.BFCS_out,
                bus.DMA_BERR, bus.DMA_BUSY}, 10'b1_1111_0_1_1_0_0);
    end
  endtask

  task automatic test_read_long();
    int lat;
    bit ok;
    start_cycle(2'b00, 2'b00, 1'b1);
    tick();
    checks++;
    if ({bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_BUSY} !== 6'b0_1111_1) begin
      errors++;
      $display("FAIL read_addr_phase got %b want %b",
               {bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_BUSY}, 6'b0_1111_1);
    end
    tick();
    checks++;
    if ({bus.DMA_DS_n, bus.DMA_DOE} !== 5'b0000_0) begin
      errors++;
      $display("FAIL read_lanes got %b want %b", {bus.DMA_DS_n, bus.DMA_DOE}, 5'b0000_0);
    end
    checks++;
    if (bus.BFCS_out !== 1'b0) begin
      errors++;
      $display("FAIL read_bfcs got %b want 0", bus.BFCS_out);
    end
    repeat (4) tick();
    checks++;
    if ({bus.DMA_DS_n, bus.SCSI_STERM_n, bus.DMA_FCS_n} !== 6'b0000_1_0) begin
      errors++;
      $display("FAIL read_waiting got %b want %b",
               {bus.DMA_DS_n, bus.SCSI_STERM_n, bus.DMA_FCS_n}, 6'b0000_1_0);
    end
    bus.ZORRO_DTACK_n = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus.SCSI_STERM_n === 1'b0) break;
    end
    checks++;
    if (lat != SYNC_STAGES + 1 || bus.SCSI_STERM_n !== 1'b0) begin
      errors++;
      $display("FAIL read_sterm_latency got %0d want %0d", lat, SYNC_STAGES + 1);
    end
    tick();
    checks++;
    if ({bus.SCSI_STERM_n, bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.DMA_BUSY} !== 8'b1_1_1111_0_1) begin
      errors++;
      $display("FAIL read_release got %b want %b",
               {bus.SCSI_STERM_n, bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.DMA_BUSY}, 8'b1_1_1111_0_1);
    end
    end_cycle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_back_to_idle got busy want idle");
    end
  endtask

  task automatic test_write_byte();
    run_txn(2'b01, 2'b01, 1'b0, 3);
    checks++;
    if ({r_ds, r_doe} !== 5'b1011_1) begin
      errors++;
      $display("FAIL write_byte_lanes got %b want %b", {r_ds, r_doe}, 5'b1011_1);
    end
    checks++;
    if (r_setup != FCS_SETUP) begin
      errors++;
      $display("FAIL write_fcs_setup got %0d want %0d", r_setup, FCS_SETUP);
    end
    checks++;
    if (!r_held || r_rel !== 7'b1_1111_0_1 || !r_ok) begin
      errors++;
      $display("FAIL write_doe_hold got held=%0d rel=%b ok=%0d want held=1 rel=1111101 ok=1",
               r_held, r_rel, r_ok);
    end
  endtask

  task automatic test_lanes();
    logic [4:0] tbl [5];
    logic [4:0] e;
    tbl[0] = {2'b10, 2'b10, 1'b0};
    tbl[1] = {2'b11, 2'b01, 1'b1};
    tbl[2] = {2'b00, 2'b10, 1'b1};
    tbl[3] = {2'b01, 2'b11, 1'b0};
    tbl[4] = {2'b10, 2'b11, 1'b1};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({~tbl[i][0], model_lanes(tbl[i][4:3], tbl[i][2:1])});
      run_txn(tbl[i][4:3], tbl[i][2:1], tbl[i][0], i);
      e = exp_q.pop_front();
      checks++;
      if ({r_doe, r_ds} !== e || !r_ok) begin
        errors++;
        $display("FAIL lanes_%0d got %b ok=%0d want %b", i, {r_doe, r_ds}, r_ok, e);
      end
    end
    checks++;
    if (model_lanes(2'b10, 2'b10) !== 4'b1100 || model_lanes(2'b11, 2'b01) !== 4'b1000) begin
      errors++;
      $display("FAIL lanes_model_anchor got %b %b want 1100 1000",
               model_lanes(2'b10, 2'b10), model_lanes(2'b11, 2'b01));
    end
  endtask

  task automatic test_random();
    logic [1:0] siz, a;
    logic       rd;
    logic [4:0] e;
    for (int i = 0; i < 12; i++) begin
      siz = 2'($urandom_range(0, 3));
      a   = 2'($urandom_range(0, 3));
      rd  = 1'($urandom_range(0, 1));
      exp_q.push_back({~rd, model_lanes(siz, a)});
      run_txn(siz, a, rd, int'($urandom_range(0, 6)));
      e = exp_q.pop_front();
      checks++;
      if ({r_doe, r_ds} !== e || r_lat != SYNC_STAGES + 1 || r_rel !== 7'b1_1111_0_1 ||
          !r_held || !r_ok) begin
        errors++;
        $display("FAIL random_%0d siz=%0d a=%0d got %b lat=%0d rel=%b want %b lat=%0d rel=1111101",
                 i, siz, a, {r_doe, r_ds}, r_lat, r_rel, e, SYNC_STAGES + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit bad;
    int n;
    // AS held low through RECOVER must not start a second cycle.
    start_cycle(2'b10, 2'b00, 1'b1);
    wait_data(n, ok);
    bus.ZORRO_DTACK_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.SCSI_STERM_n === 1'b0) break;
    end
    bus.ZORRO_DTACK_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      tick();
      if (bus.DMA_BUSY !== 1'b1 || bus.DMA_FCS_n !== 1'b1 || bus.SCSI_STERM_n !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || !ok) begin
      errors++;
      $display("FAIL b2b_hold_recover got bad=%0d ok=%0d want bad=0 ok=1", bad, ok);
    end
    end_cycle(ok);
    // Next cycle requested on the first idle clock.
    start_cycle(2'b01, 2'b10, 1'b0);
    tick();
    checks++;
    if ({bus.DMA_FCS_n, bus.DMA_BUSY} !== 2'b01 || !ok) begin
      errors++;
      $display("FAIL b2b_restart got %b ok=%0d want 01", {bus.DMA_FCS_n, bus.DMA_BUSY}, ok);
    end
    tick();
    checks++;
    if ({bus.DMA_DS_n, bus.DMA_DOE} !== {model_lanes(2'b01, 2'b10), 1'b1}) begin
      errors++;
      $display("FAIL b2b_second_lanes got %b want %b",
               {bus.DMA_DS_n, bus.DMA_DOE}, {model_lanes(2'b01, 2'b10), 1'b1});
    end
    bus.ZORRO_DTACK_n = 1'b0;
    repeat (SYNC_STAGES + 2) tick();
    end_cycle(ok);
  endtask

  task automatic test_berr(input bit with_dtack);
    bit ok, got, saw_sterm, bad;
    int n;
    start_cycle(2'b00, 2'b00, 1'b1);
    wait_data(n, ok);
    repeat (2) tick();
    bus.BERR_n = 1'b0;
    if (with_dtack) bus.ZORRO_DTACK_n = 1'b0;
    got = 1'b0;
    saw_sterm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.SCSI_STERM_n === 1'b0) saw_sterm = 1'b1;
      if (bus.DMA_BERR === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || !ok || {bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.SCSI_STERM_n} !== 7'b1_1111_0_1) begin
      errors++;
      $display("FAIL berr_entry_%0d got pulse=%0d strobes=%b want pulse=1 strobes=1111101",
               with_dtack, got, {bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.SCSI_STERM_n});
    end
    bus.BERR_n = 1'b1;
    bus.ZORRO_DTACK_n = 1'b1;
    tick();
    checks++;
    if (bus.DMA_BERR !== 1'b0) begin
      errors++;
      $display("FAIL berr_pulse_width_%0d got %b want 0", with_dtack, bus.DMA_BERR);
    end
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (bus.DMA_BUSY !== 1'b1 || bus.DMA_BERR !== 1'b0) bad = 1'b1;
      if (bus.SCSI_STERM_n === 1'b0) saw_sterm = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL berr_hold_err_%0d got left ERR want stay while AS low", with_dtack);
    end
    bus.SCSI_AS_n = 1'b1;
    tick();
    checks++;
    if (bus.DMA_BUSY !== 1'b0 || saw_sterm) begin
      errors++;
      $display("FAIL berr_exit_%0d got busy=%b sterm_seen=%0d want busy=0 sterm_seen=0",
               with_dtack, bus.DMA_BUSY, saw_sterm);
    end
  endtask

  task automatic test_bmaster_drop();
    bit ok, bad;
    int n;
    start_cycle(2'b10, 2'b00, 1'b0);
    wait_data(n, ok);
    repeat (2) tick();
    bus.BMASTER = 1'b0;
    tick();
    checks++;
    if ({bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.DMA_BUSY, bus.SCSI_STERM_n, bus.DMA_BERR}
        !== 9'b1_1111_0_0_1_0 || !ok) begin
      errors++;
      $display("FAIL bmaster_drop got %b want %b",
               {bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.DMA_BUSY, bus.SCSI_STERM_n, bus.DMA_BERR},
               9'b1_1111_0_0_1_0);
    end
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (bus.SCSI_STERM_n !== 1'b1 || bus.DMA_BERR !== 1'b0 || bus.DMA_BUSY !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bmaster_drop_quiet got activity want none");
    end
    bus.SCSI_AS_n = 1'b1;
    bus.BMASTER   = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    start_cycle(2'b00, 2'b00, 1'b1);
    wait_data(n, ok);
`ifdef DMA_TIMEOUT_EN
    begin
      bit got;
      got = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        n++;
        if (bus.DMA_BERR === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got || n != TB_TIMEOUT || bus.SCSI_STERM_n !== 1'b1) begin
        errors++;
        $display("FAIL timeout_berr got pulse=%0d after %0d want pulse=1 after %0d",
                 got, n, TB_TIMEOUT);
      end
      end_cycle(ok);
    end
`else
    begin
      bit bad;
      bad = 1'b0;
      repeat (1000) begin
        tick();
        if (bus.DMA_BERR !== 1'b0 || bus.SCSI_STERM_n !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad || !ok || bus.DMA_BUSY !== 1'b1 || bus.DMA_DS_n !== 4'b0000) begin
        errors++;
        $display("FAIL no_timeout got busy=%b ds=%b bad=%0d want busy=1 ds=0000 bad=0",
                 bus.DMA_BUSY, bus.DMA_DS_n, bad);
      end
      bus.ZORRO_DTACK_n = 1'b0;
      repeat (SYNC_STAGES + 2) tick();
      end_cycle(ok);
    end
`endif
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_cleanup got busy want idle");
    end
  endtask

  task automatic test_bfcs();
    bus.BMASTER     = 1'b0;
    bus.ZORRO_FCS_n = 1'b0;
    tick();
    checks++;
    if (bus.BFCS_out !== 1'b0) begin
      errors++;
      $display("FAIL bfcs_slave_low got %b want 0", bus.BFCS_out);
    end
    bus.ZORRO_FCS_n = 1'b1;
    tick();
    checks++;
    if (bus.BFCS_out !== 1'b1) begin
      errors++;
      $display("FAIL bfcs_slave_high got %b want 1", bus.BFCS_out);
    end
    bus.ZORRO_FCS_n = 1'b0;
    tick();
    bus.BMASTER = 1'b1;
    tick();
    checks++;
    if (bus.BFCS_out !== 1'b1) begin
      errors++;
      $display("FAIL bfcs_master_path got %b want 1", bus.BFCS_out);
    end
    bus.ZORRO_FCS_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_midcycle();
    bit ok;
    int n;
    start_cycle(2'b11, 2'b01, 1'b0);
    wait_data(n, ok);
    tick();
    #3;
    RESET = 1'b1;
    #1;
    checks++;
    if ({bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.SCSI_STERM_n, bus.BFCS_out,
         bus.DMA_BERR, bus.DMA_BUSY} !== 10'b1_1111_0_1_1_0_0 || !ok) begin
      errors++;
      $display("FAIL async_reset got %b want %b",
               {bus.DMA_FCS_n, bus.DMA_DS_n, bus.DMA_DOE, bus.SCSI_STERM_n, bus.BFCS_out,
                bus.DMA_BERR, bus.DMA_BUSY}, 10'b1_1111_0_1_1_0_0);
    end
    idle_inputs();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RESET = 1'b1;
    idle_inputs();
    test_reset();
    test_read_long();
    test_write_byte();
    test_lanes();
    test_random();
    test_back_to_back();
    test_berr(1'b0);
    test_berr(1'b1);
    test_bmaster_drop();
    test_timeout();
    test_bfcs();
    test_reset_midcycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
